// File: rtl/game_pkg.sv
// Shared types and widths for the reaction-game sequencer, decoder and display path.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam int REACTION_W = 14;
    localparam int CD_W       = 4;
    localparam int MS_PER_SEC = 1000;
    localparam int MS_W       = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle ms_tick; clear restarts the period
// so the first tick lands exactly TICK_DIV cycles after a clear.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic ms_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ms_tick_q, ms_tick_d;

    // Next prescaler count and registered wrap flag
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ms_tick_d = (cnt_d == LAST);
    end

    // Prescaler state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            ms_tick_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ms_tick_q <= ms_tick_d;
        end
    end

    assign ms_tick = ms_tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Reaction-game state engine: turns start/hit buttons into phase levels,
// the countdown digit and the measured reaction time.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int COUNT_SECS = 3,
    parameter int TIMEOUT_MS = 5000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_btn,
    input  logic                  hit_btn,
    output logic                  countdown_start,
    output logic                  game_start,
    output logic                  game_finish,
    output logic [CD_W-1:0]       countdown_val,
    output logic [REACTION_W-1:0] reaction_ms,
    output logic                  timeout,
    output logic                  false_start
);

    localparam logic [CD_W-1:0]       CD_INIT = CD_W'(COUNT_SECS);
    localparam logic [REACTION_W-1:0] TO_MAX  = REACTION_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0]       MS_LAST = MS_W'(MS_PER_SEC - 1);

    state_e                state_q, state_d;
    logic [CD_W-1:0]       countdown_val_q, countdown_val_d;
    logic [MS_W-1:0]       ms_in_sec_q, ms_in_sec_d;
    logic [REACTION_W-1:0] reaction_ms_q, reaction_ms_d;
    logic                  timeout_q, timeout_d;
    logic                  false_start_q, false_start_d;
    logic                  start_prev_q, hit_prev_q;
    logic [2:0]            phase_q, phase_d;
    logic                  start_rise_s, hit_rise_s, ms_tick_s, clear_s;
    logic [REACTION_W-1:0] reaction_inc_s;

    assign start_rise_s = start_btn & ~start_prev_q;
    assign hit_rise_s   = hit_btn & ~hit_prev_q;
    // Every state entry restarts the ms period.
    assign clear_s      = (state_d != state_q);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_s),
        .ms_tick (ms_tick_s)
    );

    // Next state, counters and results
    always_comb begin
        state_d         = state_q;
        countdown_val_d = countdown_val_q;
        ms_in_sec_d     = ms_in_sec_q;
        reaction_ms_d   = reaction_ms_q;
        timeout_d       = timeout_q;
        false_start_d   = false_start_q;
        // A tick coinciding with a hit still counts, so a hit on the timeout tick reports TIMEOUT_MS.
        reaction_inc_s  = ms_tick_s ? (reaction_ms_q + REACTION_W'(1)) : reaction_ms_q;

        case (state_q)
            IDLE: begin
                if (start_rise_s) begin
                    state_d = COUNTDOWN;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNTDOWN: begin
                if (hit_rise_s) begin
                    state_d         = DONE;
                    false_start_d   = 1'b1;
                    countdown_val_d = '0;
                end else if (ms_tick_s) begin
                    if (ms_in_sec_q == MS_LAST) begin
                        ms_in_sec_d = '0;
                        if (countdown_val_q == CD_W'(1)) begin
                            state_d         = PLAY;
                            countdown_val_d = '0;
                            reaction_ms_d   = '0;
                        end else begin
                            countdown_val_d = countdown_val_q - CD_W'(1);
                        end
                    end else begin
                        ms_in_sec_d = ms_in_sec_q + MS_W'(1);
                    end
                end else begin
                    state_d = COUNTDOWN;
                end
            end
            PLAY: begin
                if (hit_rise_s) begin
                    state_d       = DONE;
                    reaction_ms_d = reaction_inc_s;
                end else if (ms_tick_s) begin
                    reaction_ms_d = reaction_inc_s;
                    if (reaction_inc_s == TO_MAX) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    state_d = PLAY;
                end
            end
            DONE: begin
                if (start_rise_s) begin
                    state_d = COUNTDOWN;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == COUNTDOWN) && (state_q != COUNTDOWN)) begin
            countdown_val_d = CD_INIT;
            ms_in_sec_d     = '0;
            reaction_ms_d   = '0;
            timeout_d       = 1'b0;
            false_start_d   = 1'b0;
        end else begin
            ms_in_sec_d = ms_in_sec_d;
        end

        case (state_d)
            COUNTDOWN: phase_d = 3'b100;
            PLAY:      phase_d = 3'b010;
            DONE:      phase_d = 3'b001;
            default:   phase_d = 3'b000;
        endcase
    end

    // State, counter, result and button-history registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            countdown_val_q <= '0;
            ms_in_sec_q     <= '0;
            reaction_ms_q   <= '0;
            timeout_q       <= 1'b0;
            false_start_q   <= 1'b0;
            start_prev_q    <= 1'b0;
            hit_prev_q      <= 1'b0;
            phase_q         <= 3'b000;
        end else begin
            state_q         <= state_d;
            countdown_val_q <= countdown_val_d;
            ms_in_sec_q     <= ms_in_sec_d;
            reaction_ms_q   <= reaction_ms_d;
            timeout_q       <= timeout_d;
            false_start_q   <= false_start_d;
            start_prev_q    <= start_btn;
            hit_prev_q      <= hit_btn;
            phase_q         <= phase_d;
        end
    end

    assign countdown_start = phase_q[2];
    assign game_start      = phase_q[1];
    assign game_finish     = phase_q[0];
    assign countdown_val   = countdown_val_q;
    assign reaction_ms     = reaction_ms_q;
    assign timeout         = timeout_q;
    assign false_start     = false_start_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scoreboard bench for game_sequencer with TICK_DIV=4, COUNT_SECS=3, TIMEOUT_MS=50.
module tb_game_sequencer;

    localparam logic [2:0] PH_IDLE = 3'b000;
    localparam logic [2:0] PH_CD   = 3'b100;
    localparam logic [2:0] PH_PLAY = 3'b010;
    localparam logic [2:0] PH_DONE = 3'b001;

    logic        clk;
    logic        reset_n;
    logic        start_btn;
    logic        hit_btn;
    logic        countdown_start;
    logic        game_start;
    logic        game_finish;
    logic [3:0]  countdown_val;
    logic [13:0] reaction_ms;
    logic        timeout;
    logic        false_start;

    typedef struct {
        string       tag;
        logic [22:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    game_sequencer #(
        .TICK_DIV   (4),
        .COUNT_SECS (3),
        .TIMEOUT_MS (50)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_btn       (start_btn),
        .hit_btn         (hit_btn),
        .countdown_start (countdown_start),
        .game_start      (game_start),
        .game_finish     (game_finish),
        .countdown_val   (countdown_val),
        .reaction_ms     (reaction_ms),
        .timeout         (timeout),
        .false_start     (false_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input logic [2:0] ph, input logic [3:0] cdv,
                            input logic [13:0] rms, input logic to, input logic fs);
        exp_t e;
        e.tag = tag;
        e.v   = {ph, cdv, rms, to, fs};
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [22:0] obs;
        e   = sb_q.pop_front();
        obs = {countdown_start, game_start, game_finish, countdown_val, reaction_ms, timeout, false_start};
        n_checks++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed ph=%b cdv=%0d rms=%0d to=%b fs=%b, expected ph=%b cdv=%0d rms=%0d to=%b fs=%b",
                   e.tag, obs[22:20], obs[19:16], obs[15:2], obs[1], obs[0],
                   e.v[22:20], e.v[19:16], e.v[15:2], e.v[1], e.v[0]);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start_btn = 1'b0;
        hit_btn   = 1'b0;
        wait_n(3);
        push_exp("reset_state", PH_IDLE, 4'd0, 14'd0, 1'b0, 1'b0);
        check_out();
        reset_n = 1'b1;
        wait_n(1);

        // Start pulse and countdown timing
        start_btn = 1'b1;
        push_exp("cd_entry", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        start_btn = 1'b0;
        push_exp("cd_3_last", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(3999);
        check_out();
        push_exp("cd_2_at_4000", PH_CD, 4'd2, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        push_exp("cd_2_last", PH_CD, 4'd2, 14'd0, 1'b0, 1'b0);
        wait_n(3999);
        check_out();
        push_exp("cd_1_at_8000", PH_CD, 4'd1, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        push_exp("cd_1_last", PH_CD, 4'd1, 14'd0, 1'b0, 1'b0);
        wait_n(3999);
        check_out();
        push_exp("play_at_12000", PH_PLAY, 4'd0, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();

        // Normal hit 100 cycles into PLAY
        push_exp("play_99", PH_PLAY, 4'd0, 14'd24, 1'b0, 1'b0);
        wait_n(99);
        check_out();
        hit_btn = 1'b1;
        push_exp("hit_25", PH_DONE, 4'd0, 14'd25, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        hit_btn = 1'b0;
        wait_n(5);
        hit_btn = 1'b1;
        push_exp("done_ignores_hit", PH_DONE, 4'd0, 14'd25, 1'b0, 1'b0);
        wait_n(3);
        check_out();
        hit_btn = 1'b0;

        // Timeout with start held through the whole game
        start_btn = 1'b1;
        push_exp("restart_clears", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        push_exp("play_entry_b", PH_PLAY, 4'd0, 14'd0, 1'b0, 1'b0);
        wait_n(12000);
        check_out();
        push_exp("play_199", PH_PLAY, 4'd0, 14'd49, 1'b0, 1'b0);
        wait_n(199);
        check_out();
        push_exp("timeout_200", PH_DONE, 4'd0, 14'd50, 1'b1, 1'b0);
        wait_n(1);
        check_out();
        push_exp("held_start_no_restart", PH_DONE, 4'd0, 14'd50, 1'b1, 1'b0);
        wait_n(30);
        check_out();

        // Hit on exactly the timeout tick
        start_btn = 1'b0;
        wait_n(1);
        start_btn = 1'b1;
        push_exp("restart_c", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        start_btn = 1'b0;
        wait_n(12199);
        hit_btn = 1'b1;
        push_exp("hit_at_timeout", PH_DONE, 4'd0, 14'd50, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        hit_btn = 1'b0;

        // False start at cycle 5000 of COUNTDOWN
        start_btn = 1'b1;
        push_exp("restart_d", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        start_btn = 1'b0;
        push_exp("cd_4999", PH_CD, 4'd2, 14'd0, 1'b0, 1'b0);
        wait_n(4998);
        check_out();
        hit_btn = 1'b1;
        push_exp("false_start", PH_DONE, 4'd0, 14'd0, 1'b0, 1'b1);
        wait_n(1);
        check_out();
        hit_btn = 1'b0;

        // Hit held from COUNTDOWN past the PLAY entry time
        start_btn = 1'b1;
        push_exp("restart_e", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        start_btn = 1'b0;
        wait_n(9);
        hit_btn = 1'b1;
        push_exp("false_start_held", PH_DONE, 4'd0, 14'd0, 1'b0, 1'b1);
        wait_n(1);
        check_out();
        push_exp("held_hit_single", PH_DONE, 4'd0, 14'd0, 1'b0, 1'b1);
        wait_n(12100);
        check_out();
        hit_btn = 1'b0;

        // Asynchronous reset mid-PLAY with start held
        start_btn = 1'b1;
        push_exp("restart_f", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        push_exp("play_entry_f", PH_PLAY, 4'd0, 14'd0, 1'b0, 1'b0);
        wait_n(12000);
        check_out();
        push_exp("play_40", PH_PLAY, 4'd0, 14'd10, 1'b0, 1'b0);
        wait_n(40);
        check_out();
        reset_n = 1'b0;
        push_exp("async_reset", PH_IDLE, 4'd0, 14'd0, 1'b0, 1'b0);
        #1;
        check_out();
        wait_n(3);
        reset_n = 1'b1;
        push_exp("rise_after_reset", PH_CD, 4'd3, 14'd0, 1'b0, 1'b0);
        wait_n(1);
        check_out();
        start_btn = 1'b0;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
